// File: rtl/cdc_evt_arb.sv
// rtl/cdc_evt_arb.sv - round-robin event arbiter with 4-phase req/ack handshake from aclk to bclk
// Optional saturating drop counter enabled by CDC_EVT_ARB_DROP_CNT_EN.
`timescale 1ns/1ps
module cdc_evt_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            aclk,
  input  logic            rst_n,
  input  logic            bclk,
  input  logic [NREQ-1:0] pulse_in,
  output logic            busy,
  output logic [NREQ-1:0] pend,
  output logic [7:0]      drop_cnt,
  output logic            pulse_out,
  output logic [IDW-1:0]  id_out
);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  localparam logic [IDW:0]   NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ-1);

  state_t          state;
  logic            req_a;
  logic [IDW-1:0]  id_a;
  logic [IDW-1:0]  ptr;
  logic            ack_s1, ack_s2;
  logic            req_s1, req_s2, req_s3;
  logic            ack_b;

  logic [NREQ-1:0] rot;
  logic [IDW:0]    sum;
  logic [IDW-1:0]  win;
  logic            found;
  logic            grant;
  logic [NREQ-1:0] clr;

  // Rotate pend so bit 0 is the requester at ptr, then take the first set bit.
  always_comb begin
    rot   = NREQ'({pend, pend} >> ptr);
    win   = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= NREQ_W) sum = sum - NREQ_W;
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  assign grant = (state == IDLE) && found;
  assign clr   = grant ? (NREQ'(1) << win) : '0;

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      req_a <= 1'b0;
      id_a  <= '0;
      ptr   <= '0;
      pend  <= '0;
    end else begin
      // A new pulse wins over the grant-clear on the same bit.
      pend <= (pend & ~clr) | pulse_in;
      case (state)
        IDLE: if (grant) begin
          state <= REQ;
          busy  <= 1'b1;
          req_a <= 1'b1;
          id_a  <= win;
          ptr   <= (win == LAST_ID) ? '0 : win + IDW'(1);
        end
        REQ: if (ack_s2) begin
          state <= REL;
          req_a <= 1'b0;
        end
        REL: if (!ack_s2) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          req_a <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= ack_b;
      ack_s2 <= ack_s1;
    end
  end

  // id_a is stable while req_a is high, so sampling it on the req rising edge is safe.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      req_s1 <= 1'b0;
      req_s2 <= 1'b0;
      req_s3 <= 1'b0;
      id_out <= '0;
    end else begin
      req_s1 <= req_a;
      req_s2 <= req_s1;
      req_s3 <= req_s2;
      if (req_s1 && !req_s2) id_out <= id_a;
    end
  end

  assign pulse_out = req_s2 & ~req_s3;
  assign ack_b     = req_s2;

`ifdef CDC_EVT_ARB_DROP_CNT_EN
  logic [NREQ-1:0] hits;
  logic [3:0]      nhit;
  logic [8:0]      tot;
  logic [7:0]      drop_q;

  always_comb begin
    hits = pulse_in & pend & ~clr;
    nhit = '0;
    for (int k = 0; k < NREQ; k++) nhit = nhit + 4'(hits[k]);
    tot = {1'b0, drop_q} + {5'b0, nhit};
  end

  always_ff @(posedge aclk or negedge rst_n) begin
    if (!rst_n) drop_q <= 8'h00;
    else        drop_q <= tot[8] ? 8'hFF : tot[7:0];
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_cdc_evt_arb.sv
// tb/tb_cdc_evt_arb.sv - vector table plus id scoreboard for cdc_evt_arb
`timescale 1ns/1ps
module tb_cdc_evt_arb;

  logic       aclk = 1'b0;
  logic       bclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] pulse_in = 4'b0;
  logic       busy;
  logic [3:0] pend;
  logic [7:0] drop_cnt;
  logic       pulse_out;
  logic [1:0] id_out;

  real bclk_half = 7.0;

  cdc_evt_arb #(.NREQ(4), .IDW(2)) dut (
    .aclk(aclk), .rst_n(rst_n), .bclk(bclk), .pulse_in(pulse_in),
    .busy(busy), .pend(pend), .drop_cnt(drop_cnt),
    .pulse_out(pulse_out), .id_out(id_out)
  );

  always #5 aclk = ~aclk;
  initial forever #(bclk_half) bclk = ~bclk;

`ifdef CDC_EVT_ARB_DROP_CNT_EN
  localparam int EXP_DROP4 = 4;
  localparam int EXP_SAT   = 255;
`else
  localparam int EXP_DROP4 = 0;
  localparam int EXP_SAT   = 0;
`endif

  typedef struct packed {
    logic [3:0] pulse;
    logic [2:0] n;
    logic [7:0] ids;
  } vec_t;

  vec_t       tbl [5];
  int         checks = 0;
  int         passes = 0;
  logic [1:0] exp_q [$];
  bit         sb_en = 1'b1;
  int         post_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge bclk) begin
    if (pulse_out) begin
      post_cnt++;
      if (sb_en) begin
        if (exp_q.size() == 0) check("unexpected_pulse", 1, 0);
        else check("id_out", int'(id_out), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic do_reset();
    exp_q.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge aclk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [3:0] p);
    @(posedge aclk);
    #1 pulse_in = p;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 400) begin
      @(negedge aclk);
      n++;
    end
    check(name, (n < 400) ? 1 : 0, 1);
  endtask

  initial begin
    tbl[0] = '{pulse: 4'b0100, n: 3'd1, ids: 8'h02};
    tbl[1] = '{pulse: 4'b1111, n: 3'd4, ids: 8'hE4};
    tbl[2] = '{pulse: 4'b0011, n: 3'd2, ids: 8'h04};
    tbl[3] = '{pulse: 4'b1010, n: 3'd2, ids: 8'h0D};
    tbl[4] = '{pulse: 4'b1000, n: 3'd1, ids: 8'h03};

    repeat (3) @(negedge aclk);
    check("rst_busy", busy, 0);
    check("rst_pend", pend, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_pulse_out", pulse_out, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      do_reset();
      for (int j = 0; j < int'(tbl[i].n); j++) exp_q.push_back(tbl[i].ids[2*j +: 2]);
      drive(tbl[i].pulse);
      drive(4'b0);
      wait_idle("vec_done");
      check("vec_pend", pend, 0);
      check("vec_busy", busy, 0);
      check("vec_drop", drop_cnt, 0);
    end

    do_reset();
    exp_q.push_back(2'd3);
    drive(4'b1000);
    drive(4'b0);
    wait_idle("wrap_first");
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    drive(4'b1001);
    drive(4'b0);
    wait_idle("wrap_done");
    check("wrap_pend", pend, 0);

    do_reset();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    drive(4'b0001);
    repeat (5) drive(4'b0010);
    drive(4'b0);
    wait_idle("drop_done");
    check("drop_cnt4", drop_cnt, EXP_DROP4);

    do_reset();
    sb_en = 1'b0;
    drive(4'b1111);
    repeat (150) @(posedge aclk);
    drive(4'b0);
    wait_idle("sat_done");
    check("drop_sat", drop_cnt, EXP_SAT);
    sb_en = 1'b1;

    do_reset();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd0);
    drive(4'b0001);
    drive(4'b0001);
    drive(4'b0);
    wait_idle("setclr_done");
    check("setclr_drop", drop_cnt, 0);
    check("setclr_pend", pend, 0);

    for (int r = 0; r < 2; r++) begin
      int n;
      bclk_half = (r == 0) ? 15.0 : (5.0 / 3.0);
      repeat (4) @(negedge aclk);
      do_reset();
      sb_en = 1'b0;
      drive(4'b0111);
      drive(4'b0);
      n = 0;
      while (!busy && n < 20) begin
        @(negedge aclk);
        n++;
      end
      check("midreq_busy_seen", busy, 1);
      rst_n = 1'b0;
      #1;
      check("midreq_rst_busy", busy, 0);
      check("midreq_rst_pulse", pulse_out, 0);
      check("midreq_rst_pend", pend, 0);
      repeat (2) @(negedge aclk);
      post_cnt = 0;
      rst_n = 1'b1;
      repeat (40) @(negedge aclk);
      check("midreq_no_pulse", post_cnt, 0);
      check("midreq_busy", busy, 0);
      check("midreq_pend", pend, 0);
      sb_en = 1'b1;
      exp_q.push_back(2'd1);
      drive(4'b0010);
      drive(4'b0);
      wait_idle("midreq_resume");
    end

    bclk_half = 7.0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
